// File: rtl/max_pool_ctrl_if.sv
// Handshake and memory-bus bundle between the pooling sequencer and its
// environment (feature-map memory, output memory, external max_pool unit).
interface max_pool_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              start;
    logic [ADDR_W-1:0] in_base;
    logic [ADDR_W-1:0] out_base;
    logic              busy;
    logic              done;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] mp_in1;
    logic [DATA_W-1:0] mp_in2;
    logic [DATA_W-1:0] mp_in3;
    logic [DATA_W-1:0] mp_in4;
    logic              mp_en;
    logic [DATA_W-1:0] mp_value;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    // Sequencer side
    modport master (
        input  start, in_base, out_base, rd_data, mp_value,
        output busy, done, rd_en, rd_addr, mp_in1, mp_in2, mp_in3, mp_in4,
               mp_en, wr_en, wr_addr, wr_data
    );

    // Environment side
    modport slave (
        output start, in_base, out_base, rd_data, mp_value,
        input  busy, done, rd_en, rd_addr, mp_in1, mp_in2, mp_in3, mp_in4,
               mp_en, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/max_pool_ctrl.sv
// 2x2 stride-2 max-pool sequencer: walks the windows of an IN_H x IN_W map,
// gathers four pixels per window, drives the external max_pool unit for
// POOL_LAT cycles and writes each result to consecutive output addresses.
module max_pool_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 10,
    parameter int IN_H     = 4,
    parameter int IN_W     = 4,
    parameter int POOL_LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    max_pool_ctrl_if.master bus
);
    localparam int OUT_H = IN_H / 2;
    localparam int OUT_W = IN_W / 2;
    localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int PW    = (POOL_LAT > 1) ? $clog2(POOL_LAT) : 1;

    typedef enum logic [3:0] {IDLE, RD0, RD1, RD2, RD3, CAP, POOL, WR, DONE} state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0]           in_base_q;
    logic [ADDR_W-1:0]           out_base_q;
    logic [ADDR_W-1:0]           k_q;        // output index, raster order
    logic [RW-1:0]               row_q;      // window row index
    logic [CW-1:0]               col_q;      // window column index
    logic [PW-1:0]               pool_cnt;
    logic [3:0][DATA_W-1:0]      px_q;       // window pixels, [0] feeds mp_in1

    logic              last_win;
    logic              pool_last;
    logic [ADDR_W-1:0] win_off;
    logic [ADDR_W-1:0] pix_off;
    logic              busy, done, rd_en, mp_en, wr_en;

    assign last_win  = (row_q == RW'(OUT_H - 1)) && (col_q == CW'(OUT_W - 1));
    assign pool_last = (pool_cnt == PW'(POOL_LAT - 1));
    // top-left pixel of the current window relative to in_base
    assign win_off   = ADDR_W'(2 * int'(row_q) * IN_W + 2 * int'(col_q));

    // offset of the pixel fetched in the current read state
    always_comb begin
        pix_off = '0;
        unique case (state)
            RD1:     pix_off = ADDR_W'(1);
            RD2:     pix_off = ADDR_W'(IN_W);
            RD3:     pix_off = ADDR_W'(IN_W + 1);
            default: pix_off = '0;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // next-state and strobe decode
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        mp_en    = 1'b0;
        wr_en    = 1'b0;
        unique case (state)
            IDLE: if (bus.start) state_nx = RD0;
            RD0:  begin busy = 1'b1; rd_en = 1'b1; state_nx = RD1; end
            RD1:  begin busy = 1'b1; rd_en = 1'b1; state_nx = RD2; end
            RD2:  begin busy = 1'b1; rd_en = 1'b1; state_nx = RD3; end
            RD3:  begin busy = 1'b1; rd_en = 1'b1; state_nx = CAP; end
            CAP:  begin busy = 1'b1; state_nx = POOL; end
            POOL: begin
                busy  = 1'b1;
                mp_en = 1'b1;
                if (pool_last) state_nx = WR;
            end
            WR:   begin
                busy  = 1'b1;
                wr_en = 1'b1;
                state_nx = last_win ? DONE : RD0;
            end
            DONE: begin done = 1'b1; state_nx = IDLE; end
            default: state_nx = IDLE;
        endcase
    end

    // bases, window counters, pool counter and pixel capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_base_q  <= '0;
            out_base_q <= '0;
            k_q        <= '0;
            row_q      <= '0;
            col_q      <= '0;
            pool_cnt   <= '0;
            px_q       <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.start) begin
                    in_base_q  <= bus.in_base;
                    out_base_q <= bus.out_base;
                    k_q        <= '0;
                    row_q      <= '0;
                    col_q      <= '0;
                end
                // read data lags the strobe by one cycle
                RD1:  px_q[0] <= bus.rd_data;
                RD2:  px_q[1] <= bus.rd_data;
                RD3:  px_q[2] <= bus.rd_data;
                CAP:  begin
                    px_q[3]  <= bus.rd_data;
                    pool_cnt <= '0;
                end
                POOL: pool_cnt <= pool_cnt + 1'b1;
                WR:   begin
                    k_q <= k_q + 1'b1;
                    if (col_q == CW'(OUT_W - 1)) begin
                        col_q <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_en ? (in_base_q + win_off + pix_off) : '0;
    assign bus.mp_en   = mp_en;
    assign bus.mp_in1  = px_q[0];
    assign bus.mp_in2  = px_q[1];
    assign bus.mp_in3  = px_q[2];
    assign bus.mp_in4  = px_q[3];
    assign bus.wr_en   = wr_en;
    assign bus.wr_addr = wr_en ? (out_base_q + k_q) : '0;
    assign bus.wr_data = wr_en ? bus.mp_value : '0;
endmodule

// File: tb/tb_max_pool_ctrl.sv
// Bench for max_pool_ctrl: a 4x4 and a 5x5 instance share one feature-map
// memory; each has its own registered max_pool unit and an event monitor.
module tb_max_pool_ctrl;
    localparam int DW = 8;
    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    max_pool_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) i4 ();
    max_pool_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) i5 ();

    max_pool_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IN_H(4), .IN_W(4), .POOL_LAT(1))
        u4 (.clk(clk), .rst_n(rst_n), .bus(i4.master));
    max_pool_ctrl #(.DATA_W(DW), .ADDR_W(AW), .IN_H(5), .IN_W(5), .POOL_LAT(1))
        u5 (.clk(clk), .rst_n(rst_n), .bus(i5.master));

    logic [DW-1:0] mem [1024];

    int n_cmp = 0;
    int n_err = 0;
    int pcnt  = 0;
    int s0    = 0;
    int viol  = 0;

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic signed [DW-1:0] m;
        m = a;
        if ($signed(b) > m) m = b;
        if ($signed(c) > m) m = c;
        if ($signed(d) > m) m = d;
        return m;
    endfunction

    // memories and max_pool units
    always @(posedge clk) begin
        pcnt <= pcnt + 1;
        i4.rd_data <= i4.rd_en ? mem[i4.rd_addr] : 8'h00;
        i5.rd_data <= i5.rd_en ? mem[i5.rd_addr] : 8'h00;
        if (i4.mp_en) i4.mp_value <= max4(i4.mp_in1, i4.mp_in2, i4.mp_in3, i4.mp_in4);
        if (i5.mp_en) i5.mp_value <= max4(i5.mp_in1, i5.mp_in2, i5.mp_in3, i5.mp_in4);
    end

    logic [AW-1:0]    rd4[$], rd5[$], grd[$], erd[$];
    logic [AW+DW-1:0] wr4[$], wr5[$], gwr[$], ewr[$];
    logic [31:0]      px4[$], px5[$], gpx[$], epx[$];
    int               dn4[$], dn5[$], gdn[$];

    // event monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (i4.rd_en) rd4.push_back(i4.rd_addr); else if (i4.rd_addr != 0) viol++;
        if (i4.wr_en) begin
            wr4.push_back({i4.wr_addr, i4.wr_data});
            px4.push_back({i4.mp_in1, i4.mp_in2, i4.mp_in3, i4.mp_in4});
        end else if (i4.wr_addr != 0 || i4.wr_data != 0) viol++;
        if (i4.done) dn4.push_back(pcnt - s0 + 1);
        if (i4.done && i4.busy) viol++;
        if (i5.rd_en) rd5.push_back(i5.rd_addr); else if (i5.rd_addr != 0) viol++;
        if (i5.wr_en) begin
            wr5.push_back({i5.wr_addr, i5.wr_data});
            px5.push_back({i5.mp_in1, i5.mp_in2, i5.mp_in3, i5.mp_in4});
        end else if (i5.wr_addr != 0 || i5.wr_data != 0) viol++;
        if (i5.done) dn5.push_back(pcnt - s0 + 1);
        if (i5.done && i5.busy) viol++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ctl(input int which);
        if (which == 0) return {27'b0, i4.busy, i4.done, i4.rd_en, i4.mp_en, i4.wr_en};
        return {27'b0, i5.busy, i5.done, i5.rd_en, i5.mp_en, i5.wr_en};
    endfunction
    function automatic logic [31:0] adr(input int which);
        if (which == 0) return {12'b0, i4.rd_addr, i4.wr_addr};
        return {12'b0, i5.rd_addr, i5.wr_addr};
    endfunction
    function automatic logic [31:0] pix(input int which);
        if (which == 0) return {i4.mp_in1, i4.mp_in2, i4.mp_in3, i4.mp_in4};
        return {i5.mp_in1, i5.mp_in2, i5.mp_in3, i5.mp_in4};
    endfunction
    function automatic logic [31:0] wdat(input int which);
        if (which == 0) return {24'b0, i4.wr_data};
        return {24'b0, i5.wr_data};
    endfunction

    task automatic zero_chk(input int which, input string tag);
        chk({tag, " ctl"},  ctl(which),  32'h0);
        chk({tag, " addr"}, adr(which),  32'h0);
        chk({tag, " mpin"}, pix(which),  32'h0);
        chk({tag, " wdat"}, wdat(which), 32'h0);
    endtask

    task automatic drive_start(input int which, input logic v, input logic [AW-1:0] ib, ob);
        if (which == 0) begin i4.start = v; i4.in_base = ib; i4.out_base = ob; end
        else            begin i5.start = v; i5.in_base = ib; i5.out_base = ob; end
    endtask

    function automatic logic cur_done(input int which);
        return (which == 0) ? i4.done : i5.done;
    endfunction

    task automatic clear_logs();
        rd4.delete(); wr4.delete(); px4.delete(); dn4.delete();
        rd5.delete(); wr5.delete(); px5.delete(); dn5.delete();
    endtask

    task automatic grab(input int which);
        if (which == 0) begin grd = rd4; gwr = wr4; gpx = px4; gdn = dn4; end
        else            begin grd = rd5; gwr = wr5; gpx = px5; gdn = dn5; end
    endtask

    // reference: every window in raster order, straight from the map geometry
    task automatic model(input int h, input int w, input logic [AW-1:0] ib, ob);
        logic [AW-1:0] a0, a1, a2, a3;
        int k;
        erd.delete(); ewr.delete(); epx.delete();
        k = 0;
        for (int r = 0; r + 1 < h; r += 2) begin
            for (int c = 0; c + 1 < w; c += 2) begin
                a0 = ib + AW'(r * w + c);
                a1 = ib + AW'(r * w + c + 1);
                a2 = ib + AW'((r + 1) * w + c);
                a3 = ib + AW'((r + 1) * w + c + 1);
                erd.push_back(a0); erd.push_back(a1); erd.push_back(a2); erd.push_back(a3);
                epx.push_back({mem[a0], mem[a1], mem[a2], mem[a3]});
                ewr.push_back({ob + AW'(k), max4(mem[a0], mem[a1], mem[a2], mem[a3])});
                k++;
            end
        end
    endtask

    task automatic check_pass(input int h, input int w, input string tag);
        int nw;
        nw = (h / 2) * (w / 2);
        chk({tag, " n_done"}, gdn.size(), 1);
        if (gdn.size() > 0) chk({tag, " done_cyc"}, gdn[0], nw * (6 + 1) + 1);
        chk({tag, " n_rd"}, grd.size(), erd.size());
        for (int i = 0; i < grd.size() && i < erd.size(); i++)
            chk($sformatf("%s rd%0d", tag, i), grd[i], erd[i]);
        chk({tag, " n_wr"}, gwr.size(), ewr.size());
        for (int i = 0; i < gwr.size() && i < ewr.size(); i++) begin
            chk($sformatf("%s wr%0d", tag, i), gwr[i], ewr[i]);
            chk($sformatf("%s px%0d", tag, i), gpx[i], epx[i]);
        end
    endtask

    task automatic run(input int which, input logic [AW-1:0] ib, ob, input bit inj,
                       input string tag);
        int h;
        h = (which == 0) ? 4 : 5;
        model(h, h, ib, ob);
        clear_logs();
        @(negedge clk); drive_start(which, 1'b1, ib, ob);
        @(posedge clk); #1; s0 = pcnt; drive_start(which, 1'b0, ib, ob);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (inj && i == 10) drive_start(which, 1'b1, ib + 10'd1, ob + 10'd1);
            if (inj && i == 11) drive_start(which, 1'b0, ib, ob);
            if (cur_done(which)) begin
                if (inj) begin
                    drive_start(which, 1'b1, ib, ob);
                    @(posedge clk); #1;
                    drive_start(which, 1'b0, ib, ob);
                end
                break;
            end
        end
        repeat (4) @(posedge clk);
        #1;
        grab(which);
        check_pass(h, h, tag);
        chk({tag, " idle_busy"}, ctl(which), 32'h0);
    endtask

    task automatic fill_mem();
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic [AW-1:0] ib, ob, off;
        rst_n = 1'b0;
        drive_start(0, 1'b0, '0, '0);
        drive_start(1, 1'b0, '0, '0);
        fill_mem();

        // reset with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            drive_start(0, 1'($urandom), AW'($urandom), AW'($urandom));
            drive_start(1, 1'($urandom), AW'($urandom), AW'($urandom));
        end
        #1;
        zero_chk(0, "rst4");
        zero_chk(1, "rst5");
        @(negedge clk);
        drive_start(0, 1'b0, '0, '0);
        drive_start(1, 1'b0, '0, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst ctl4", ctl(0), 32'h0);

        // basic pool
        mem[0] = 8'h02; mem[1] = 8'hFE; mem[4] = 8'h00; mem[5] = 8'h04;
        run(0, 10'h000, 10'h100, 1'b0, "basic");
        if (gwr.size() > 0) chk("basic first_wr", gwr[0], {10'h100, 8'h04});

        // signed window and addressing
        mem[10'h20] = 8'h80; mem[10'h21] = 8'hFF; mem[10'h24] = 8'h90; mem[10'h25] = 8'hF0;
        run(0, 10'h020, 10'h200, 1'b0, "signed");
        if (gwr.size() > 0) chk("signed wr0_data", gwr[0][DW-1:0], 8'hFF);
        if (grd.size() >= 16) begin
            chk("addr w3 rd0", grd[12], 10'h02A);
            chk("addr w3 rd1", grd[13], 10'h02B);
            chk("addr w3 rd2", grd[14], 10'h02E);
            chk("addr w3 rd3", grd[15], 10'h02F);
        end
        if (gwr.size() >= 4) chk("addr w3 wr", gwr[3][AW+DW-1:DW], 10'h203);

        // odd dimensions with ignored starts during busy and DONE
        ib = 10'h037;
        run(1, ib, 10'h150, 1'b1, "odd");
        bad = 0;
        for (int i = 0; i < grd.size(); i++) begin
            off = grd[i] - ib;
            if ((int'(off) % 5) == 4 || (int'(off) / 5) == 4) bad++;
        end
        chk("odd edge_reads", bad, 0);
        chk("odd n_rd_const", grd.size(), 16);

        // address wrap-around at the top of memory
        fill_mem();
        run(0, 10'h3FA, 10'h3FE, 1'b0, "wrap");

        // reset during POOL of window 2
        fill_mem();
        ib = AW'($urandom); ob = AW'($urandom);
        model(4, 4, ib, ob);
        clear_logs();
        @(negedge clk); drive_start(0, 1'b1, ib, ob);
        @(posedge clk); #1; s0 = pcnt; drive_start(0, 1'b0, ib, ob);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (i4.mp_en && wr4.size() == 2) break;
        end
        rst_n = 1'b0;
        #1;
        zero_chk(0, "midrst");
        repeat (5) @(posedge clk);
        #1;
        chk("midrst n_wr", wr4.size(), 2);
        chk("midrst n_rd", rd4.size(), 12);
        chk("midrst n_done", dn4.size(), 0);
        for (int i = 0; i < 2 && i < wr4.size(); i++)
            chk($sformatf("midrst wr%0d", i), wr4[i], ewr[i]);
        @(negedge clk); rst_n = 1'b1;
        run(0, AW'($urandom), AW'($urandom), 1'b0, "after_rst");

        // random passes on both instances
        for (int t = 0; t < 4; t++) begin
            fill_mem();
            run(t % 2, AW'($urandom), AW'($urandom), 1'b0, $sformatf("rnd%0d", t));
        end

        chk("protocol idle_zero", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
